// File: rtl/wb_commit.sv
// -----------------------------------------------------------------------------
// wb_commit -- writeback / commit stage
//
// Buffers retiring instructions from MEM in an in-order queue, pairs each load
// with its data beat from the in-order memory response channel (aligning and
// sign/zero-extending sub-word loads), and commits at most one register-file
// write per cycle, strictly in program order, through a registered write port.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    instruction handshake from MEM
//   in_reg_write, in_rd  destination write enable / index
//   in_src               00 ALU, 01 LOAD, 10 PC+4, 11 illegal
//   in_alu_result        ALU result
//   in_pc_plus4          PC+4 value
//   in_funct3            load size/sign (LB, LH, LW, LBU, LHU)
//   in_addr_lo           load byte offset
//   mem_rsp_valid/_data  load data beats, in load order, no backpressure
//   rf_we, rf_rd,        registered register-file write port
//   rf_wdata
//   retire_valid         registered pulse per committed entry
//   outstanding_loads    loads enqueued but not yet given data
//   empty                instruction queue empty
//   err_illegal_src      sticky: an entry with src==11 committed
//   err_unexpected_rsp   sticky: a beat arrived with no load outstanding
// -----------------------------------------------------------------------------
module wb_commit #(
  parameter int DEPTH = 4,
  parameter int RD_W  = 5,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_reg_write,
  input  logic [RD_W-1:0]          in_rd,
  input  logic [1:0]               in_src,
  input  logic [XLEN-1:0]          in_alu_result,
  input  logic [XLEN-1:0]          in_pc_plus4,
  input  logic [2:0]               in_funct3,
  input  logic [1:0]               in_addr_lo,
  input  logic                     mem_rsp_valid,
  input  logic [XLEN-1:0]          mem_rsp_data,
  output logic                     rf_we,
  output logic [RD_W-1:0]          rf_rd,
  output logic [XLEN-1:0]          rf_wdata,
  output logic                     retire_valid,
  output logic [$clog2(DEPTH):0]   outstanding_loads,
  output logic                     empty,
  output logic                     err_illegal_src,
  output logic                     err_unexpected_rsp
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_ILL  = 2'b11
  } src_e;

  // Non-load data (ALU or PC+4) is selected at enqueue so only one word is stored.
  typedef struct packed {
    logic            reg_write;
    logic [RD_W-1:0] rd;
    src_e            src;
    logic [XLEN-1:0] data;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
  } iq_entry_t;

  // Load alignment and extension. Pointer-style shifts select the byte/half.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      funct3,
                                                  input logic [1:0]      addr_lo);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = 8'(word >> {addr_lo, 3'b000});
    half_sel = 16'(word >> {addr_lo[1], 4'b0000});
    case (funct3)
      3'b000:  return {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b100:  return {{(XLEN-8){1'b0}}, byte_sel};
      3'b001:  return {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b101:  return {{(XLEN-16){1'b0}}, half_sel};
      default: return word;
    endcase
  endfunction

  // Storage
  iq_entry_t       iq_mem_q [DEPTH];
  logic [XLEN-1:0] rq_mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CW-1:0]   iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
  logic [CW-1:0]   rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;

  logic            rf_we_q, rf_we_d;
  logic [RD_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            retire_q, retire_d;
  logic            err_ill_q, err_ill_d;
  logic            err_rsp_q, err_rsp_d;

  // Combinational control
  iq_entry_t       head, new_entry;
  logic            iq_empty, iq_full, rq_empty;
  logic            in_fire, head_is_load, commit, bypass, rq_pop, rq_push, rsp_accept;
  logic [XLEN-1:0] load_word, commit_data;

  assign iq_empty = (iq_wr_q == iq_rd_q);
  assign iq_full  = ((iq_wr_q - iq_rd_q) == CW'(DEPTH));
  assign rq_empty = (rq_wr_q == rq_rd_q);

  // Ready deliberately ignores a same-cycle commit: a full queue refuses input.
  assign in_ready = !rst && !iq_full;
  assign in_fire  = in_valid && in_ready;

  assign head         = iq_mem_q[iq_rd_q[PW-1:0]];
  assign head_is_load = (head.src == SRC_LOAD);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    new_entry           = '0;
    new_entry.reg_write = in_reg_write;
    new_entry.rd        = in_rd;
    new_entry.src       = src_e'(in_src);
    new_entry.data      = (in_src == SRC_PC4) ? in_pc_plus4 : in_alu_result;
    new_entry.funct3    = in_funct3;
    new_entry.addr_lo   = in_addr_lo;
  end

  always_comb begin
    commit      = 1'b0;
    bypass      = 1'b0;
    rq_pop      = 1'b0;
    rsp_accept  = 1'b0;
    rq_push     = 1'b0;
    load_word   = rq_mem_q[rq_rd_q[PW-1:0]];
    commit_data = head.data;

    iq_wr_d       = iq_wr_q;
    iq_rd_d       = iq_rd_q;
    rq_wr_d       = rq_wr_q;
    rq_rd_d       = rq_rd_q;
    outstanding_d = outstanding_q;
    rf_we_d       = 1'b0;
    retire_d      = 1'b0;
    rf_rd_d       = rf_rd_q;
    rf_wdata_d    = rf_wdata_q;
    err_ill_d     = err_ill_q;
    err_rsp_d     = err_rsp_q;

    // A load at the head commits from the response queue, or straight from the
    // channel when the queue is empty and a beat is present this cycle.
    commit = !iq_empty && (!head_is_load || !rq_empty || mem_rsp_valid);
    bypass = commit && head_is_load && rq_empty;
    rq_pop = commit && head_is_load && !rq_empty;

    if (rq_empty) begin
      load_word = mem_rsp_data;
    end
    if (head_is_load) begin
      commit_data = load_extend(load_word, head.funct3, head.addr_lo);
    end

    if (commit) begin
      retire_d   = 1'b1;
      rf_rd_d    = head.rd;
      rf_wdata_d = commit_data;
      rf_we_d    = head.reg_write && (head.rd != '0) && (head.src != SRC_ILL);
      if (head.src == SRC_ILL) begin
        err_ill_d = 1'b1;
      end
    end

    // Beats with nothing outstanding are dropped; accepted beats not taken by
    // bypass wait in the response queue, which the counter keeps from overflowing.
    rsp_accept = mem_rsp_valid && (outstanding_q != '0);
    rq_push    = rsp_accept && !bypass;
    if (mem_rsp_valid && (outstanding_q == '0)) begin
      err_rsp_d = 1'b1;
    end

    iq_wr_d       = iq_wr_q + CW'(in_fire);
    iq_rd_d       = iq_rd_q + CW'(commit);
    rq_wr_d       = rq_wr_q + CW'(rq_push);
    rq_rd_d       = rq_rd_q + CW'(rq_pop);
    outstanding_d = outstanding_q + CW'(in_fire && (in_src == SRC_LOAD)) - CW'(rsp_accept);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      iq_wr_q       <= '0;
      iq_rd_q       <= '0;
      rq_wr_q       <= '0;
      rq_rd_q       <= '0;
      outstanding_q <= '0;
      rf_we_q       <= 1'b0;
      rf_rd_q       <= '0;
      rf_wdata_q    <= '0;
      retire_q      <= 1'b0;
      err_ill_q     <= 1'b0;
      err_rsp_q     <= 1'b0;
    end else begin
      iq_wr_q       <= iq_wr_d;
      iq_rd_q       <= iq_rd_d;
      rq_wr_q       <= rq_wr_d;
      rq_rd_q       <= rq_rd_d;
      outstanding_q <= outstanding_d;
      rf_we_q       <= rf_we_d;
      rf_rd_q       <= rf_rd_d;
      rf_wdata_q    <= rf_wdata_d;
      retire_q      <= retire_d;
      err_ill_q     <= err_ill_d;
      err_rsp_q     <= err_rsp_d;
    end
  end

  // NOTE: queue storage is not reset; resetting the pointers makes its contents invisible.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      iq_mem_q[iq_wr_q[PW-1:0]] <= new_entry;
    end
    if (rq_push) begin
      rq_mem_q[rq_wr_q[PW-1:0]] <= mem_rsp_data;
    end
  end

  assign rf_we              = rf_we_q;
  assign rf_rd              = rf_rd_q;
  assign rf_wdata           = rf_wdata_q;
  assign retire_valid       = retire_q;
  assign outstanding_loads  = outstanding_q;
  assign empty              = iq_empty;
  assign err_illegal_src    = err_ill_q;
  assign err_unexpected_rsp = err_rsp_q;

endmodule
